// File: rtl/encode_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module      : encode_bitstream_packer
// Description : Packs variable-length Golomb codewords MSB-first into a bit
//               accumulator. Emits bytes on a valid/ready interface with
//               marker bit-stuffing after 0xFF. Zero-pads the tail on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module encode_bitstream_packer #(
  parameter int ENCODEDPIXEL_WIDTH    = 32,
  parameter int ENCODEDLENGTH_WIDTH   = 6,
  parameter int REMAINDERVALUE_LENGTH = 9,
  parameter int ACC_WIDTH             = 96,
  parameter int COUNT_WIDTH           = 7
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ENCODEDPIXEL_WIDTH-1:0]    encoded_pixel,
  input  logic [ENCODEDLENGTH_WIDTH-1:0]   encoded_length,
  input  logic [REMAINDERVALUE_LENGTH-1:0] remainder_value,
  input  logic                             limit_overflow,
  input  logic                             flush,
  output logic [7:0]                       out_byte,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             flush_done,
  output logic [COUNT_WIDTH-1:0]           bits_pending
);

  // Largest symbol: all-ones zero prefix plus the full escape suffix.
  localparam int C_SYM_MAX = (2 ** ENCODEDLENGTH_WIDTH) - 1 + REMAINDERVALUE_LENGTH;
  localparam logic [COUNT_WIDTH-1:0] C_READY_LIMIT = COUNT_WIDTH'(ACC_WIDTH - C_SYM_MAX);
  localparam logic [COUNT_WIDTH-1:0] C_ACC_BITS    = COUNT_WIDTH'(ACC_WIDTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Valid bits live MSB-aligned in acc_q; everything below them is kept zero
  // so a flush pad byte is simply the top of the accumulator.
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   stuff_q, stuff_d;
  logic                   rdy_en_q;
  state_t                 state_q, state_d;

  logic [COUNT_WIDTH-1:0] w_need;
  logic                   w_full;
  logic                   w_pad;
  logic                   w_emit;
  logic                   w_accept;
  logic [COUNT_WIDTH-1:0] w_consumed;
  logic [COUNT_WIDTH-1:0] w_remain;
  logic [COUNT_WIDTH-1:0] w_len;
  logic [COUNT_WIDTH-1:0] w_shl;
  logic [ACC_WIDTH-1:0]   w_sym;
  logic [ACC_WIDTH-1:0]   w_sym_msb;

  // Output side and symbol formatting, all derived from registers or inputs.
  always_comb begin
    w_need     = stuff_q ? COUNT_WIDTH'(7) : COUNT_WIDTH'(8);
    w_full     = (cnt_q >= w_need);
    w_pad      = (state_q == ST_FLUSH) && (cnt_q != '0) && !w_full;
    out_valid  = w_full || w_pad;
    out_byte   = stuff_q ? {1'b0, acc_q[ACC_WIDTH-1 -: 7]} : acc_q[ACC_WIDTH-1 -: 8];
    w_emit     = out_valid && out_ready;
    w_consumed = w_emit ? (w_full ? w_need : cnt_q) : '0;
    w_remain   = cnt_q - w_consumed;

    in_ready   = rdy_en_q && (state_q == ST_RUN) && (cnt_q <= C_READY_LIMIT);
    w_accept   = in_valid && in_ready;

    // Escape symbols carry their zero prefix implicitly as leading zeros.
    if (limit_overflow) begin
      w_len = COUNT_WIDTH'(encoded_length) + COUNT_WIDTH'(REMAINDERVALUE_LENGTH);
      w_sym = ACC_WIDTH'(remainder_value);
    end else begin
      w_len = COUNT_WIDTH'(encoded_length);
      w_sym = ACC_WIDTH'(encoded_pixel) & ~({ACC_WIDTH{1'b1}} << encoded_length);
    end
    // A zero-length symbol shifts out entirely and contributes nothing.
    w_shl     = C_ACC_BITS - w_len;
    w_sym_msb = w_sym << w_shl;
  end

  // Next accumulator, fill count, stuff flag and flush sequencing.
  always_comb begin
    acc_d   = acc_q << w_consumed;
    cnt_d   = w_remain;
    stuff_d = stuff_q;
    state_d = state_q;

    if (w_accept) begin
      acc_d = acc_d | (w_sym_msb >> w_remain);
      cnt_d = w_remain + w_len;
    end
    if (w_emit) begin
      stuff_d = (out_byte == 8'hFF);
    end

    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        stuff_d = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign flush_done   = (state_q == ST_DONE);
  assign bits_pending = cnt_q;

  // State registers; reset discards any pending bits outright.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      stuff_q  <= 1'b0;
      rdy_en_q <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      stuff_q  <= stuff_d;
      rdy_en_q <= 1'b1;
      state_q  <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_encode_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_encode_bitstream_packer
// Description : Directed self-checking bench for encode_bitstream_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encode_bitstream_packer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] encoded_pixel;
  logic [5:0]  encoded_length;
  logic [8:0]  remainder_value;
  logic        limit_overflow;
  logic        flush;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        flush_done;
  logic [6:0]  bits_pending;

  int n_checks = 0;
  int n_fail   = 0;

  encode_bitstream_packer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .encoded_pixel   (encoded_pixel),
    .encoded_length  (encoded_length),
    .remainder_value (remainder_value),
    .limit_overflow  (limit_overflow),
    .flush           (flush),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .flush_done      (flush_done),
    .bits_pending    (bits_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one symbol and hold it until accepted (bounded wait).
  task automatic send(input logic [5:0] len, input logic [31:0] pix,
                      input logic lo, input logic [8:0] rem);
    int t;
    t = 0;
    in_valid        = 1'b1;
    encoded_length  = len;
    encoded_pixel   = pix;
    limit_overflow  = lo;
    remainder_value = rem;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Take one byte from the output port and compare it (bounded wait).
  task automatic get_byte(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    check(tag, {24'd0, out_byte}, {24'd0, exp});
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [7:0] bp_exp [6];
    bp_exp = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};

    reset_n = 1'b0; in_valid = 1'b0; encoded_pixel = '0; encoded_length = '0;
    remainder_value = '0; limit_overflow = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_byte", {24'd0, out_byte}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    check("rst_rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Single byte
    send(6'd8, 32'hFFFF_FFA5, 1'b0, 9'd0);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_byte", {24'd0, out_byte}, 32'h0000_00A5);
    get_byte("single_take", 8'hA5);
    check("single_pending", {25'd0, bits_pending}, 32'd0);

    // Stuffing after 0xFF, then pad on flush
    send(6'd8, 32'h0000_00FF, 1'b0, 9'd0);
    send(6'd8, 32'h0000_0080, 1'b0, 9'd0);
    get_byte("stuff_ff", 8'hFF);
    get_byte("stuff_40", 8'h40);
    check("stuff_pending", {25'd0, bits_pending}, 32'd1);
    do_flush();
    get_byte("stuff_pad", 8'h00);
    check("stuff_done", {31'd0, flush_done}, 32'd1);
    tick();
    check("stuff_done_pulse", {31'd0, flush_done}, 32'd0);
    tick();

    // Escape format: 14 zeros then 1_1111_1111
    send(6'd14, 32'hFFFF_FFFF, 1'b1, 9'h1FF);
    check("esc_pending", {25'd0, bits_pending}, 32'd23);
    do_flush();
    check("esc_in_ready_flush", {31'd0, in_ready}, 32'd0);
    get_byte("esc_b0", 8'h00);
    get_byte("esc_b1", 8'h03);
    get_byte("esc_b2", 8'hFE);
    check("esc_done", {31'd0, flush_done}, 32'd1);
    tick();
    check("esc_done_pulse", {31'd0, flush_done}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    send(6'd24, 32'h0012_3456, 1'b0, 9'd0);
    check("bp_ready_24", {31'd0, in_ready}, 32'd1);
    send(6'd24, 32'h0012_3456, 1'b0, 9'd0);
    check("bp_ready_48", {31'd0, in_ready}, 32'd0);
    check("bp_byte", {24'd0, out_byte}, 32'h12);
    in_valid = 1'b1; encoded_length = 6'd8; encoded_pixel = 32'hEE;
    tick(); tick();
    in_valid = 1'b0;
    check("bp_hold_byte", {24'd0, out_byte}, 32'h12);
    check("bp_no_accept", {25'd0, bits_pending}, 32'd48);
    for (int i = 0; i < 6; i++) get_byte($sformatf("bp_byte%0d", i), bp_exp[i]);
    check("bp_drained", {25'd0, bits_pending}, 32'd0);

    // Accept and emit in the same cycle
    send(6'd16, 32'h0000_C3D2, 1'b0, 9'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; encoded_length = 6'd4; encoded_pixel = 32'h9; limit_overflow = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("sim_pending", {25'd0, bits_pending}, 32'd12);
    get_byte("sim_b1", 8'hD2);
    check("sim_tail", {25'd0, bits_pending}, 32'd4);
    do_flush();
    get_byte("sim_pad", 8'h90);
    tick(); tick();

    // Reset mid-stream
    send(6'd13, 32'h0000_1ABC, 1'b0, 9'd0);
    check("mid_pending", {25'd0, bits_pending}, 32'd13);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_pending", {25'd0, bits_pending}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send(6'd8, 32'h0000_003C, 1'b0, 9'd0);
    get_byte("mid_after", 8'h3C);

    // Zero-length symbol, then flush with nothing pending after 0xFF
    send(6'd0, 32'hFFFF_FFFF, 1'b0, 9'd0);
    check("zero_pending", {25'd0, bits_pending}, 32'd0);
    check("zero_valid", {31'd0, out_valid}, 32'd0);
    send(6'd8, 32'h0000_00FF, 1'b0, 9'd0);
    get_byte("edge_ff", 8'hFF);
    do_flush();
    check("edge_no_byte", {31'd0, out_valid}, 32'd0);
    tick();
    check("edge_done", {31'd0, flush_done}, 32'd1);
    check("edge_no_byte2", {31'd0, out_valid}, 32'd0);
    tick();
    send(6'd8, 32'h0000_00A5, 1'b0, 9'd0);
    get_byte("edge_unstuffed", 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
